// File: rtl/nanov_load_serializer_if.sv
// rtl/nanov_load_serializer_if.sv - memory-read / serial register-write bus for the load serializer
interface nanov_load_serializer_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  start;
  logic [2:0]            funct3;
  logic [1:0]            addr_lo;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_valid;
  logic                  pause;
  logic                  busy;
  logic [REG_ADDR_W-1:0] rd;
  logic                  wr_en;
  logic                  data_rd;
  logic [4:0]            counter;
  logic                  done;
  logic                  err;

  modport master (
    output start, funct3, addr_lo, rd_in, mem_data, mem_valid, pause,
    input  busy, rd, wr_en, data_rd, counter, done, err
  );

  modport slave (
    input  start, funct3, addr_lo, rd_in, mem_data, mem_valid, pause,
    output busy, rd, wr_en, data_rd, counter, done, err
  );
endinterface

// File: rtl/nanov_load_serializer.sv
// rtl/nanov_load_serializer.sv - parallel load word to LSB-first serial register write (option: NANOV_LOAD_MISALIGN_ERR_EN)
module nanov_load_serializer #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  nanov_load_serializer_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT} state_e;

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       word_q, word_d;
  logic [4:0]            counter_q, counter_d;
  logic [XLEN-1:0]       ext_word;
  logic [XLEN-1:0]       lane_b;
  logic [XLEN-1:0]       lane_h;
  logic                  wr_en;
  logic                  done;

`ifdef NANOV_LOAD_MISALIGN_ERR_EN
  logic err_q, err_d;
  logic misaligned;

  // Halfword loads need an even offset, word-class loads need offset 0.
  assign misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr_lo[0]) ||
                      (bus.funct3[1] && (bus.addr_lo != 2'b00));
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Lane select and RV32 sign/zero extension of the raw memory word.
  always_comb begin
    lane_b   = bus.mem_data >> {addr_lo_q, 3'b000};
    lane_h   = bus.mem_data >> {addr_lo_q[1], 4'b0000};
    ext_word = bus.mem_data;
    case (funct3_q)
      3'b000:  ext_word = {{24{lane_b[7]}}, lane_b[7:0]};
      3'b100:  ext_word = {24'd0, lane_b[7:0]};
      3'b001:  ext_word = {{16{lane_h[15]}}, lane_h[15:0]};
      3'b101:  ext_word = {16'd0, lane_h[15:0]};
      default: ext_word = bus.mem_data;
    endcase
  end

  // Next-state and serial-write control.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    rd_d      = rd_q;
    word_d    = word_q;
    counter_d = counter_q;
    wr_en     = 1'b0;
    done      = 1'b0;
`ifdef NANOV_LOAD_MISALIGN_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          funct3_d  = bus.funct3;
          addr_lo_d = bus.addr_lo;
          rd_d      = bus.rd_in;
`ifdef NANOV_LOAD_MISALIGN_ERR_EN
          if (misaligned) err_d = 1'b1;
          else            state_d = ST_WAIT;
`else
          state_d   = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        if (bus.mem_valid) begin
          word_d    = ext_word;
          counter_d = 5'd0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!bus.pause) begin
          wr_en = 1'b1;
          if (counter_q == 5'd31) begin
            done      = 1'b1;
            counter_d = 5'd0;
            state_d   = ST_IDLE;
          end else begin
            counter_d = counter_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      funct3_q  <= 3'd0;
      addr_lo_q <= 2'd0;
      rd_q      <= '0;
      word_q    <= '0;
      counter_q <= 5'd0;
`ifdef NANOV_LOAD_MISALIGN_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      rd_q      <= rd_d;
      word_q    <= word_d;
      counter_q <= counter_d;
`ifdef NANOV_LOAD_MISALIGN_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.rd      = rd_q;
  assign bus.counter = counter_q;
  assign bus.data_rd = word_q[counter_q];
  assign bus.wr_en   = wr_en;
  assign bus.done    = done;
endmodule

// File: tb/tb_nanov_load_serializer.sv
// tb/tb_nanov_load_serializer.sv - directed self-checking bench for nanov_load_serializer
module tb_nanov_load_serializer;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  nanov_load_serializer_if bus();

  nanov_load_serializer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load with no pause: start, one WAIT cycle, 32 serial bits, idle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [3:0] rdi, input logic [31:0] data, input logic [31:0] exp);
    logic [31:0] got;
    got = '0;
    bus.start = 1'b1; bus.funct3 = f3; bus.addr_lo = alo; bus.rd_in = rdi;
    step();
    bus.start = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_data = data;
    #2;
    chk({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_wait_wr_en"}, 32'(bus.wr_en), 32'd0);
    step();
    bus.mem_valid = 1'b0; bus.mem_data = ~data;
    for (int i = 0; i < 32; i++) begin
      #2;
      chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd1);
      chk({tag, "_counter"}, 32'(bus.counter), i);
      chk({tag, "_done"}, 32'(bus.done), (i == 31) ? 32'd1 : 32'd0);
      got[i] = bus.data_rd;
      if (i == 0) chk({tag, "_rd"}, 32'(bus.rd), 32'(rdi));
      step();
    end
    #2;
    chk({tag, "_value"}, got, exp);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_wr_en_end"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    step();
  endtask

  initial begin
    logic [31:0] got;
    int          j, c0, c31, ndone, done_cyc;
    logic        p;
    checks = 0; errors = 0;
    rstn = 1'b0;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.addr_lo = 2'd0; bus.rd_in = 4'd0;
    bus.mem_data = 32'd0; bus.mem_valid = 1'b0; bus.pause = 1'b0;
    step(); step();
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_counter", 32'(bus.counter), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_data_rd", 32'(bus.data_rd), 32'd0);
    rstn = 1'b1;
    step();

    do_load("lw",    3'b010, 2'd0, 4'd5,  32'hDEADBEEF, 32'hDEADBEEF);
    do_load("lb",    3'b000, 2'd2, 4'd3,  32'h12C3A455, 32'hFFFFFFC3);
    do_load("lbu",   3'b100, 2'd2, 4'd3,  32'h12C3A455, 32'h000000C3);
    do_load("lh",    3'b001, 2'd2, 4'd7,  32'h8001FFFF, 32'hFFFF8001);
    do_load("lhu",   3'b101, 2'd2, 4'd7,  32'h8001FFFF, 32'h00008001);
    do_load("lb3",   3'b000, 2'd3, 4'd1,  32'h80123456, 32'hFFFFFF80);
    do_load("lh0",   3'b001, 2'd0, 4'd2,  32'h12347FFF, 32'h00007FFF);
    do_load("lw111", 3'b111, 2'd0, 4'd0,  32'hA5A50F0F, 32'hA5A50F0F);

    // Pause on bit 0 for 3 cycles and on bit 31 for 2 cycles.
    bus.start = 1'b1; bus.funct3 = 3'b010; bus.addr_lo = 2'd0; bus.rd_in = 4'd9;
    step();
    bus.start = 1'b0; bus.mem_valid = 1'b1; bus.mem_data = 32'h00000001;
    step();
    bus.mem_valid = 1'b0; bus.mem_data = 32'hFFFFFFFE;
    got = '0; j = 0; c0 = 0; c31 = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 37; cyc++) begin
      p = ((j == 0) && (c0 < 3)) || ((j == 31) && (c31 < 2));
      bus.pause = p;
      #2;
      chk("pause_counter", 32'(bus.counter), j);
      chk("pause_wr_en", 32'(bus.wr_en), p ? 32'd0 : 32'd1);
      if (bus.done) done_cyc = cyc;
      if (p) begin
        if (j == 0) c0++; else c31++;
      end else begin
        got[j] = bus.data_rd;
        j++;
      end
      step();
    end
    bus.pause = 1'b0;
    #2;
    chk("pause_value", got, 32'h00000001);
    chk("pause_done_cycle", 32'(done_cyc), 32'd37);
    chk("pause_busy_end", 32'(bus.busy), 32'd0);
    step();

    // start while shifting is ignored: exactly one done.
    bus.start = 1'b1; bus.funct3 = 3'b010; bus.addr_lo = 2'd0; bus.rd_in = 4'd4;
    step();
    bus.start = 1'b0; bus.mem_valid = 1'b1; bus.mem_data = 32'h0F0F0F0F;
    step();
    bus.mem_valid = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.start = (cyc == 5);
      #2;
      if (bus.done) ndone++;
      step();
    end
    bus.start = 1'b0;
    #2;
    chk("start_busy_ndone", 32'(ndone), 32'd1);
    chk("start_busy_idle", 32'(bus.busy), 32'd0);
    step();

    // Reset mid-operation at counter 10.
    bus.start = 1'b1; bus.funct3 = 3'b010; bus.addr_lo = 2'd0; bus.rd_in = 4'd6;
    step();
    bus.start = 1'b0; bus.mem_valid = 1'b1; bus.mem_data = 32'hFFFFFFFF;
    step();
    bus.mem_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    #2;
    chk("rst_mid_counter", 32'(bus.counter), 32'd10);
    rstn = 1'b0;
    step();
    #2;
    chk("rst_mid_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_cnt0", 32'(bus.counter), 32'd0);
    rstn = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      #2;
      if (bus.done || bus.wr_en) ndone++;
    end
    chk("rst_mid_no_activity", 32'(ndone), 32'd0);
    step();

    // mem_valid while idle does nothing.
    bus.mem_valid = 1'b1; bus.mem_data = 32'h55AA55AA;
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      #2;
      if (bus.busy || bus.wr_en || bus.done) ndone++;
    end
    bus.mem_valid = 1'b0;
    chk("idle_mem_valid", 32'(ndone), 32'd0);
    step();

`ifdef NANOV_LOAD_MISALIGN_ERR_EN
    bus.start = 1'b1; bus.funct3 = 3'b010; bus.addr_lo = 2'd1; bus.rd_in = 4'd8;
    #2;
    chk("mis_err_pre", 32'(bus.err), 32'd0);
    step();
    bus.start = 1'b0; bus.mem_valid = 1'b1; bus.mem_data = 32'h13572468;
    #2;
    chk("mis_err", 32'(bus.err), 32'd1);
    chk("mis_busy", 32'(bus.busy), 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      #2;
      if (bus.err || bus.busy || bus.wr_en || bus.done) ndone++;
    end
    bus.mem_valid = 1'b0;
    chk("mis_no_activity", 32'(ndone), 32'd0);
    step();
`else
    do_load("lw_mis", 3'b010, 2'd1, 4'd8, 32'h13572468, 32'h13572468);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
